tone_source_arbiter: RTL and testbench

- Sits between the 7-key keyboard scanner / octave debouncers and the buzzer tone generator.
- Shares the single tone generator between two requesters:
  - live keyboard play;
  - a melody sequencer that plays notes from a synchronous song ROM.
- Live play always has priority.
- Outputs one registered note request per cycle: key id, active flag and octave controls. The existing tone generator consumes these unchanged.

---
 rtl/tone_source_arbiter.sv | 229 ++++++++++++++++++++++
 tb/tb_tone_source_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_source_arbiter.sv
// rtl/tone_source_arbiter.sv - Shares the buzzer tone generator between live keyboard play and a ROM melody sequencer
//
// Purpose:
//   Live keyboard play always wins the tone generator. When no key is held, a
//   melody sequencer walks a synchronous song ROM (one-cycle read latency).
//   For each ROM entry it plays the note for max(dur,1)*BEAT_CYCLES cycles and
//   then stays silent for GAP_CYCLES cycles. Octave code 11 marks the end of
//   the song. The tone request to the generator is registered (one-cycle
//   latency from the inputs and the state).
//
// Ports:
//   clk                 system clock (50 MHz)
//   rst_n               synchronous active-low reset
//   live_key_id[2:0]    scanner key id, 1..7 = C..B
//   live_key_pressed    scanner key-pressed flag
//   live_oct_up/down    debounced octave controls from the keyboard
//   play_start          one-cycle pulse, starts the song at address 0
//   play_stop           one-cycle pulse, aborts the song
//   rom_addr            song ROM address
//   rom_data[7:0]       ROM word {dur[7:5], octave code[4:3], note id[2:0]}
//   tone_key_id/active/oct_up/oct_down  registered request to the tone generator
//   playing             sequencer is in any state other than IDLE
//   song_done           one-cycle pulse on the natural end of the song
//
// Build option:
//   LIVE_ABORT_EN  defined: a rising edge of live_key_pressed while playing
//                  aborts the song like play_stop.
//                  undefined: a held live key freezes the sequencer, which
//                  resumes with the remaining duration when the key is released.

module tone_source_arbiter #(
  parameter int BEAT_CYCLES = 12500000,
  parameter int GAP_CYCLES  = 2500000,
  parameter int ADDR_W      = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        live_key_id,
  input  logic              live_key_pressed,
  input  logic              live_oct_up,
  input  logic              live_oct_down,
  input  logic              play_start,
  input  logic              play_stop,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [2:0]        tone_key_id,
  output logic              tone_active,
  output logic              tone_oct_up,
  output logic              tone_oct_down,
  output logic              playing,
  output logic              song_done
);

  // A parameter of 1 would give a zero-width counter; keep at least one bit.
  localparam int BEAT_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_NOTE,
    S_GAP,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]          note_q, note_d;
  logic [1:0]          oct_q, oct_d;
  logic [2:0]          dur_q, dur_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [2:0]          unit_q, unit_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [2:0]          tone_key_d;
  logic                tone_active_d;
  logic                tone_up_d;
  logic                tone_dn_d;
  logic                stop_req;
  logic                hold;
  logic [2:0]          unit_last;

`ifdef LIVE_ABORT_EN
  logic live_prev_q;

  // A fresh key press ends the song; a key already held when the song starts
  // only overrides the output and does not abort.
  assign stop_req = play_stop | (live_key_pressed & ~live_prev_q);
  assign hold     = 1'b0;
`else
  assign stop_req = play_stop;
  assign hold     = live_key_pressed && (state_q != S_IDLE) && (state_q != S_DONE);
`endif

  // Duration 0 plays as one unit.
  assign unit_last = (dur_q == 3'd0) ? 3'd0 : dur_q - 3'd1;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    note_d  = note_q;
    oct_d   = oct_q;
    dur_d   = dur_q;
    beat_d  = beat_q;
    unit_d  = unit_q;
    gap_d   = gap_q;

    if ((state_q != S_IDLE) && stop_req) begin
      state_d = S_IDLE;
    end else if (!hold) begin
      case (state_q)
        S_IDLE: begin
          if (play_start && !play_stop) begin
            state_d = S_FETCH;
            addr_d  = '0;
          end
        end
        S_FETCH: state_d = S_LOAD;
        S_LOAD: begin
          note_d = rom_data[2:0];
          oct_d  = rom_data[4:3];
          dur_d  = rom_data[7:5];
          if (rom_data[4:3] == 2'b11) begin
            state_d = S_DONE;
          end else begin
            state_d = S_NOTE;
            beat_d  = '0;
            unit_d  = '0;
          end
        end
        S_NOTE: begin
          if (beat_q == BEAT_LAST) begin
            beat_d = '0;
            if (unit_q == unit_last) begin
              state_d = S_GAP;
              gap_d   = '0;
            end else begin
              unit_d = unit_q + 3'd1;
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) begin
            if (addr_q == ADDR_LAST) begin
              state_d = S_DONE;
            end else begin
              addr_d  = addr_q + 1'b1;
              state_d = S_FETCH;
            end
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output mux. The sequencer's note is muted in the cycle a stop is taken so
  // the tone drops together with playing.
  always_comb begin
    tone_key_d    = 3'd0;
    tone_active_d = 1'b0;
    tone_up_d     = 1'b0;
    tone_dn_d     = 1'b0;
    if (live_key_pressed) begin
      tone_key_d    = live_key_id;
      tone_active_d = 1'b1;
      tone_up_d     = live_oct_up;
      tone_dn_d     = live_oct_down;
    end else if ((state_q == S_NOTE) && (note_q != 3'd0) && !stop_req) begin
      tone_key_d    = note_q;
      tone_active_d = 1'b1;
      tone_up_d     = (oct_q == 2'b01);
      tone_dn_d     = (oct_q == 2'b10);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      note_q        <= '0;
      oct_q         <= '0;
      dur_q         <= '0;
      beat_q        <= '0;
      unit_q        <= '0;
      gap_q         <= '0;
      tone_key_id   <= '0;
      tone_active   <= 1'b0;
      tone_oct_up   <= 1'b0;
      tone_oct_down <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      note_q        <= note_d;
      oct_q         <= oct_d;
      dur_q         <= dur_d;
      beat_q        <= beat_d;
      unit_q        <= unit_d;
      gap_q         <= gap_d;
      tone_key_id   <= tone_key_d;
      tone_active   <= tone_active_d;
      tone_oct_up   <= tone_up_d;
      tone_oct_down <= tone_dn_d;
    end
  end

`ifdef LIVE_ABORT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      live_prev_q <= 1'b0;
    end else begin
      live_prev_q <= live_key_pressed;
    end
  end
`endif

  assign rom_addr  = addr_q;
  assign playing   = (state_q != S_IDLE);
  assign song_done = (state_q == S_DONE);

endmodule

// File: tb/tb_tone_source_arbiter.sv
// tb/tb_tone_source_arbiter.sv - Table-driven self-checking bench for tone_source_arbiter

module tb_tone_source_arbiter;

  localparam int BEAT_CYCLES = 4;
  localparam int GAP_CYCLES  = 2;
  localparam int ADDR_W      = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [2:0]        live_key_id = 3'd0;
  logic              live_key_pressed = 1'b0;
  logic              live_oct_up = 1'b0;
  logic              live_oct_down = 1'b0;
  logic              play_start = 1'b0;
  logic              play_stop = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data = 8'h00;
  logic [2:0]        tone_key_id;
  logic              tone_active;
  logic              tone_oct_up;
  logic              tone_oct_down;
  logic              playing;
  logic              song_done;

  logic [7:0] rom [8];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  tone_source_arbiter #(
    .BEAT_CYCLES(BEAT_CYCLES),
    .GAP_CYCLES (GAP_CYCLES),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .live_key_id     (live_key_id),
    .live_key_pressed(live_key_pressed),
    .live_oct_up     (live_oct_up),
    .live_oct_down   (live_oct_down),
    .play_start      (play_start),
    .play_stop       (play_stop),
    .rom_addr        (rom_addr),
    .rom_data        (rom_data),
    .tone_key_id     (tone_key_id),
    .tone_active     (tone_active),
    .tone_oct_up     (tone_oct_up),
    .tone_oct_down   (tone_oct_down),
    .playing         (playing),
    .song_done       (song_done)
  );

  // One record per clock: inputs sampled at an edge and the outputs expected
  // just after that edge.
  typedef struct packed {
    logic       rstn;
    logic       start;
    logic       stop;
    logic       live;
    logic [2:0] lid;
    logic       lup;
    logic       ldn;
    logic [2:0] ekey;
    logic       eact;
    logic       eup;
    logic       edn;
    logic       eplay;
    logic       edone;
  } vec_t;

  vec_t vq[$];

  function automatic void seg(input int n, input logic st, input logic sp, input logic lv,
                              input logic [2:0] lid, input logic lu, input logic ld,
                              input logic [2:0] ek, input logic ea, input logic eu,
                              input logic ed, input logic ep, input logic edn);
    vec_t v;
    v.rstn = 1'b1; v.start = st; v.stop = sp; v.live = lv;
    v.lid = lid; v.lup = lu; v.ldn = ld;
    v.ekey = ek; v.eact = ea; v.eup = eu; v.edn = ed; v.eplay = ep; v.edone = edn;
    for (int i = 0; i < n; i++) vq.push_back(v);
  endfunction

  function automatic void rst_seg(input int n);
    vec_t v;
    v = '0;
    for (int i = 0; i < n; i++) vq.push_back(v);
  endfunction

  function automatic void quiet(input int n, input logic ep, input logic edn);
    seg(n, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, ep, edn);
  endfunction

  function automatic void note(input int n, input logic [2:0] k, input logic u, input logic d);
    seg(n, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, k, 1'b1, u, d, 1'b1, 1'b0);
  endfunction

  function automatic void start_vec();
    seg(1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endfunction

  task automatic run_vecs(input string name);
    logic [7:0] got, exp;
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      rst_n            = vq[i].rstn;
      play_start       = vq[i].start;
      play_stop        = vq[i].stop;
      live_key_pressed = vq[i].live;
      live_key_id      = vq[i].lid;
      live_oct_up      = vq[i].lup;
      live_oct_down    = vq[i].ldn;
      @(posedge clk);
      #1;
      got = {tone_key_id, tone_active, tone_oct_up, tone_oct_down, playing, song_done};
      exp = {vq[i].ekey, vq[i].eact, vq[i].eup, vq[i].edn, vq[i].eplay, vq[i].edone};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s vec %0d: got key=%0d act=%b up=%b dn=%b playing=%b done=%b, expected key=%0d act=%b up=%b dn=%b playing=%b done=%b",
                 name, i, got[7:5], got[4], got[3], got[2], got[1], got[0],
                 exp[7:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1; play_start = 1'b0; play_stop = 1'b0;
    live_key_pressed = 1'b0; live_key_id = 3'd0; live_oct_up = 1'b0; live_oct_down = 1'b0;
    vq.delete();
  endtask

  task automatic check_addr(input string name, input logic [ADDR_W-1:0] exp);
    n_checks++;
    if (rom_addr !== exp) begin
      n_fail++;
      $display("FAIL %s: rom_addr got %0d, expected %0d", name, rom_addr, exp);
    end
  endtask

  task automatic rom_song(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    for (int i = 0; i < 8; i++) rom[i] = 8'h18;
    rom[0] = a; rom[1] = b; rom[2] = c;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rom[i] = 8'h00;

    // Reset state
    rst_seg(2);
    run_vecs("reset");
    check_addr("reset_addr", 3'd0);

    // 1: two notes then end marker
    rom_song(8'h23, 8'h45, 8'h18);
    start_vec();
    quiet(2, 1'b1, 1'b0);
    note(4, 3'd3, 1'b0, 1'b0);
    quiet(4, 1'b1, 1'b0);
    note(8, 3'd5, 1'b0, 1'b0);
    quiet(3, 1'b1, 1'b0);
    quiet(1, 1'b1, 1'b1);
    quiet(1, 1'b0, 1'b0);
    run_vecs("song1");

    // 2: rest of 3 units, then duration-0 note with octave up
    rom_song(8'h60, 8'h0A, 8'h18);
    start_vec();
    quiet(18, 1'b1, 1'b0);
    note(4, 3'd2, 1'b1, 1'b0);
    quiet(3, 1'b1, 1'b0);
    quiet(1, 1'b1, 1'b1);
    quiet(1, 1'b0, 1'b0);
    run_vecs("rest_dur0");

    // 3: live key 6 held 10 cycles, two cycles into a 2-unit note
    rom_song(8'h45, 8'h18, 8'h18);
    start_vec();
    quiet(2, 1'b1, 1'b0);
    note(2, 3'd5, 1'b0, 1'b0);
`ifdef LIVE_ABORT_EN
    seg(10, 1'b0, 1'b0, 1'b1, 3'd6, 1'b0, 1'b1, 3'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    quiet(20, 1'b0, 1'b0);
`else
    seg(10, 1'b0, 1'b0, 1'b1, 3'd6, 1'b0, 1'b1, 3'd6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    note(6, 3'd5, 1'b0, 1'b0);
    quiet(3, 1'b1, 1'b0);
    quiet(1, 1'b1, 1'b1);
    quiet(1, 1'b0, 1'b0);
`endif
    run_vecs("live_preempt");

    // 4: start ignored while playing, stop mid-note, start+stop in IDLE
    start_vec();
    quiet(2, 1'b1, 1'b0);
    seg(1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    note(1, 3'd5, 1'b0, 1'b0);
    seg(1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    quiet(3, 1'b0, 1'b0);
    seg(1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    quiet(3, 1'b0, 1'b0);
    run_vecs("stop");

    // 5: full 8-entry ROM without end marker
    for (int k = 0; k < 8; k++) rom[k] = 8'h20 | 8'((k % 7) + 1);
    for (int k = 0; k < 8; k++) begin
      if (k == 0) start_vec();
      else quiet(1, 1'b1, 1'b0);
      quiet(2, 1'b1, 1'b0);
      note(4, 3'((k % 7) + 1), 1'b0, 1'b0);
      quiet(1, 1'b1, 1'b0);
    end
    quiet(1, 1'b1, 1'b1);
    quiet(2, 1'b0, 1'b0);
    run_vecs("full_rom");
    check_addr("full_rom_last_addr", 3'd7);

    // 6: reset during the second gap, then restart from address 0
    rom_song(8'h23, 8'h45, 8'h18);
    start_vec();
    quiet(2, 1'b1, 1'b0);
    note(4, 3'd3, 1'b0, 1'b0);
    quiet(4, 1'b1, 1'b0);
    note(8, 3'd5, 1'b0, 1'b0);
    rst_seg(1);
    quiet(2, 1'b0, 1'b0);
    run_vecs("reset_in_gap");
    check_addr("reset_in_gap_addr", 3'd0);

    start_vec();
    quiet(2, 1'b1, 1'b0);
    note(4, 3'd3, 1'b0, 1'b0);
    seg(1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    quiet(2, 1'b0, 1'b0);
    run_vecs("restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
